muldiv_ctrl: RTL and testbench

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

---
 rtl/muldiv_ctrl.sv | 164 ++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - multiply/divide sequencer producing 64-bit HI/LO results
// Optional flush port enabled by the MULDIV_FLUSH_EN macro.
module muldiv_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  control,
    input  logic [31:0] a,
    input  logic [31:0] b,
`ifdef MULDIV_FLUSH_EN
    input  logic        flush,
`endif
    output logic        stall,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic        r_uns;
    logic [4:0]  r_cnt;
    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_bm;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_flush;
    logic        w_valid;
    logic        w_accept;
    logic        w_sgn_in;
    logic [63:0] w_prod;
    logic [32:0] w_rem_sh;
    logic [32:0] w_diff;
    logic [31:0] w_rem_nx;
    logic [31:0] w_quo_nx;
    logic        w_q_neg;
    logic        w_r_neg;

`ifdef MULDIV_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    assign w_valid  = (control == 4'b0100) || (control == 4'b0101) ||
                      (control == 4'b1110) || (control == 4'b1111);
    assign w_accept = (r_state == S_IDLE) && start && w_valid && !w_flush;
    assign w_sgn_in = !control[0];

    assign w_prod = r_uns ? ({32'd0, r_a} * {32'd0, r_b})
                          : ($signed({{32{r_a[31]}}, r_a}) * $signed({{32{r_b[31]}}, r_b}));

    // One restoring step: shift in the next dividend bit, keep the difference if it did not borrow.
    assign w_rem_sh = {r_rem, r_quo[31]};
    assign w_diff   = w_rem_sh - {1'b0, r_bm};
    assign w_rem_nx = w_diff[32] ? w_rem_sh[31:0] : w_diff[31:0];
    assign w_quo_nx = {r_quo[30:0], !w_diff[32]};
    assign w_q_neg  = !r_uns && (r_a[31] ^ r_b[31]);
    assign w_r_neg  = !r_uns && r_a[31];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        stall  = 1'b0;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    stall  = 1'b1;
                    w_next = control[3] ? S_MUL : S_DIV;
                end
            end
            S_MUL: begin
                busy   = 1'b1;
                stall  = !w_flush;
                w_next = w_flush ? S_IDLE : S_DONE;
            end
            S_DIV: begin
                busy  = 1'b1;
                stall = !w_flush;
                if (w_flush) begin
                    w_next = S_IDLE;
                end else if (r_cnt == 5'd31) begin
                    w_next = S_DONE;
                end
            end
            default: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_uns <= 1'b0;
            r_cnt <= '0;
            r_rem <= '0;
            r_quo <= '0;
            r_bm  <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a   <= a;
                        r_b   <= b;
                        r_uns <= control[0];
                        r_cnt <= '0;
                        r_rem <= '0;
                        r_quo <= (w_sgn_in && a[31]) ? -a : a;
                        r_bm  <= (w_sgn_in && b[31]) ? -b : b;
                    end
                end
                S_MUL: begin
                    if (!w_flush) begin
                        r_hi <= w_prod[63:32];
                        r_lo <= w_prod[31:0];
                    end
                end
                S_DIV: begin
                    if (!w_flush) begin
                        r_cnt <= r_cnt + 5'd1;
                        r_rem <= w_rem_nx;
                        r_quo <= w_quo_nx;
                        if (r_cnt == 5'd31) begin
                            if (r_b == 32'd0) begin
                                r_hi <= r_a;
                                r_lo <= 32'hFFFF_FFFF;
                            end else begin
                                r_hi <= w_r_neg ? -w_rem_nx : w_rem_nx;
                                r_lo <= w_q_neg ? -w_quo_nx : w_quo_nx;
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign hi = r_hi;
    assign lo = r_lo;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - self-checking bench for muldiv_ctrl with a result scoreboard
module tb_muldiv_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  control;
    logic [31:0] a;
    logic [31:0] b;
`ifdef MULDIV_FLUSH_EN
    logic        flush;
`endif
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          total = 0;
    int          bad   = 0;
    logic [63:0] sb_q[$];
    logic [63:0] mon_exp;

    localparam logic [3:0] C_DIV   = 4'b0100;
    localparam logic [3:0] C_DIVU  = 4'b0101;
    localparam logic [3:0] C_MULT  = 4'b1110;
    localparam logic [3:0] C_MULTU = 4'b1111;

    muldiv_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .control (control),
        .a       (a),
        .b       (b),
`ifdef MULDIV_FLUSH_EN
        .flush   (flush),
`endif
        .stall   (stall),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (done === 1'b1) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_done got hi=%h lo=%h required no done", hi, lo);
            end else begin
                mon_exp = sb_q.pop_front();
                if ({hi, lo} !== mon_exp) begin
                    bad++;
                    $display("FAIL result got hi=%h lo=%h required hi=%h lo=%h",
                             hi, lo, mon_exp[63:32], mon_exp[31:0]);
                end
            end
        end
    end

    function automatic logic [63:0] model(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] p;
        logic signed [31:0] sx;
        logic signed [31:0] sy;
        sx = x;
        sy = y;
        if (c == C_MULT) begin
            p = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
            return p;
        end else if (c == C_MULTU) begin
            return {32'd0, x} * {32'd0, y};
        end else if (y == 32'd0) begin
            return {x, 32'hFFFF_FFFF};
        end else if (c == C_DIVU) begin
            return {x % y, x / y};
        end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
            return {32'd0, 32'h8000_0000};
        end
        return {32'(sx % sy), 32'(sx / sy)};
    endfunction

    // Accepts one op, scrambles inputs while it runs, checks stall each cycle and the done latency.
    task automatic issue(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y,
                         input logic [63:0] exp_res, input bit hold);
        int lat;
        bit seen;
        lat  = c[3] ? 2 : 33;
        seen = 0;
        @(negedge clk);
        start = 1'b1; control = c; a = x; b = y;
        #1;
        total++;
        if (stall !== 1'b1) begin
            bad++;
            $display("FAIL accept_stall got %b required 1", stall);
        end
        sb_q.push_back(exp_res);
        for (int k = 1; k <= lat + 3; k++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            a = $urandom;
            b = $urandom;
            #1;
            total++;
            if (stall !== (k < lat)) begin
                bad++;
                $display("FAIL stall_cycle%0d got %b required %b", k, stall, (k < lat));
            end
            if (done === 1'b1) begin
                seen = 1;
                total++;
                if (k != lat) begin
                    bad++;
                    $display("FAIL latency got %0d required %0d", k, lat);
                end
                break;
            end
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL done_timeout got none required done after %0d", lat);
            void'(sb_q.pop_back());
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; control = 4'd0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        total++;
        if ({hi, lo, busy, done, stall} !== 67'd0) begin
            bad++;
            $display("FAIL reset_state got hi=%h lo=%h busy=%b done=%b stall=%b required 0",
                     hi, lo, busy, done, stall);
        end
        rst = 1'b0;
    endtask

    task automatic test_mult();
        issue(C_MULT, 32'hFFFF_FFFE, 32'h0000_0003, {32'hFFFF_FFFF, 32'hFFFF_FFFA}, 0);
        issue(C_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001}, 0);
    endtask

    task automatic test_div();
        issue(C_DIV, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 0);
        issue(C_DIVU, 32'd7, 32'd2, {32'd1, 32'd3}, 0);
        issue(C_DIVU, 32'h1234_5678, 32'd0, {32'h1234_5678, 32'hFFFF_FFFF}, 0);
        issue(C_DIV, 32'hFFFF_FF00, 32'd0, {32'hFFFF_FF00, 32'hFFFF_FFFF}, 0);
        issue(C_DIV, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 0);
    endtask

    task automatic test_random();
        logic [3:0]  c;
        logic [31:0] x;
        logic [31:0] y;
        for (int i = 0; i < 8; i++) begin
            case (i % 4)
                0: c = C_DIV;
                1: c = C_DIVU;
                2: c = C_MULT;
                default: c = C_MULTU;
            endcase
            x = $urandom;
            y = (i == 5) ? 32'd0 : ((i % 3 == 0) ? ($urandom >> $urandom_range(31, 0)) : $urandom);
            issue(c, x, y, model(c, x, y), 0);
        end
    endtask

    task automatic test_back_to_back();
        issue(C_DIV, 32'd100, 32'hFFFF_FFF9, model(C_DIV, 32'd100, 32'hFFFF_FFF9), 1);
        issue(C_DIV, 32'd55, 32'd6, {32'd1, 32'd9}, 0);
        repeat (3) @(negedge clk);
        #1;
        total++;
        if ({hi, lo} !== {32'd1, 32'd9}) begin
            bad++;
            $display("FAIL hold_result got hi=%h lo=%h required hi=1 lo=9", hi, lo);
        end
    endtask

    task automatic test_invalid();
        @(negedge clk);
        start = 1'b1; control = 4'b0010; a = 32'd9; b = 32'd3;
        #1;
        total++;
        if (stall !== 1'b0) begin
            bad++;
            $display("FAIL invalid_stall got %b required 0", stall);
        end
        @(negedge clk);
        #1;
        total++;
        if ({busy, stall, done} !== 3'b000) begin
            bad++;
            $display("FAIL invalid_idle got busy=%b stall=%b done=%b required 000", busy, stall, done);
        end
        start = 1'b0;
    endtask

    task automatic test_reset_abort();
        int dones;
        dones = 0;
        @(negedge clk);
        start = 1'b1; control = C_DIV; a = 32'd1000; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if ({hi, lo, busy, done, stall} !== 67'd0) begin
            bad++;
            $display("FAIL reset_abort got hi=%h lo=%h busy=%b done=%b stall=%b required 0",
                     hi, lo, busy, done, stall);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            #1;
            if (done === 1'b1) dones++;
        end
        total++;
        if (dones != 0) begin
            bad++;
            $display("FAIL abort_no_done got %0d required 0", dones);
        end
        issue(C_MULT, 32'd6, 32'hFFFF_FFF9, {32'hFFFF_FFFF, 32'hFFFF_FFD6}, 0);
    endtask

`ifdef MULDIV_FLUSH_EN
    task automatic test_flush();
        int dones;
        dones = 0;
        issue(C_MULTU, 32'd3, 32'd5, {32'd0, 32'd15}, 0);
        @(negedge clk);
        start = 1'b1; control = C_DIVU; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        #1;
        total++;
        if (stall !== 1'b0) begin
            bad++;
            $display("FAIL flush_stall got %b required 0", stall);
        end
        @(negedge clk);
        flush = 1'b0;
        #1;
        total++;
        if ({busy, hi, lo} !== {1'b0, 32'd0, 32'd15}) begin
            bad++;
            $display("FAIL flush_abort got busy=%b hi=%h lo=%h required busy=0 hi=0 lo=f", busy, hi, lo);
        end
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            #1;
            if (done === 1'b1) dones++;
        end
        total++;
        if (dones != 0) begin
            bad++;
            $display("FAIL flush_no_done got %0d required 0", dones);
        end
        @(negedge clk);
        start = 1'b1; control = C_MULT; flush = 1'b1;
        #1;
        total++;
        if (stall !== 1'b0) begin
            bad++;
            $display("FAIL flush_idle_stall got %b required 0", stall);
        end
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL flush_idle_accept got busy=%b required 0", busy);
        end
        @(negedge clk);
        start = 1'b1; control = C_MULTU; a = 32'd6; b = 32'd7;
        sb_q.push_back({32'd0, 32'd42});
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        total++;
        if ({hi, lo} !== {32'd0, 32'd42}) begin
            bad++;
            $display("FAIL flush_in_done got hi=%h lo=%h required hi=0 lo=2a", hi, lo);
        end
    endtask
`endif

    initial begin
        #400000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1);
    end

    initial begin
`ifdef MULDIV_FLUSH_EN
        flush = 1'b0;
`endif
        test_reset();
        test_mult();
        test_div();
        test_invalid();
        test_back_to_back();
        test_random();
        test_reset_abort();
`ifdef MULDIV_FLUSH_EN
        test_flush();
`endif
        repeat (3) @(negedge clk);
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got %0d pending required 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
